// File: rtl/pc_tx.sv
// pc_tx: PC-bound UART transmitter. It queues 32-bit words in a FIFO and sends each word MSB byte first as 8N1 frames.
// Optional macro PC_TX_MAGIC_HEADER_EN prefixes each packet with the bytes D7 8C 1B 74.
module pc_tx #(
  parameter int CLKS_PER_BIT = 435,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_write_next_word_cmd,
  input  logic [31:0] i_fifo_input_word,
  output logic        o_fifo_is_full_sig,
  output logic        o_fifo_is_empty_sig,
  output logic        o_write_dropped_sig,
  output logic        o_tx_serial,
  output logic        o_tx_active_sig,
  output logic        o_word_sent_sig,
  output logic        o_debug_out_b,
  output logic        o_debug_out_y
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [31:0]   HEADER_WORD = 32'hD78C_1B74;
  localparam logic [7:0]    HEADER_MSB  = 8'hD7;
`ifdef PC_TX_MAGIC_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_LOAD = 2'd1;
  localparam logic [1:0] W_SEND = 2'd2;

  logic [1:0]    state_reg;
  logic [1:0]    byte_idx_reg;
  logic [31:0]   shift_reg;
  logic          hdr_req_reg;
  logic          hdr_active_reg;
  logic          drained_reg;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [31:0]   fifo_q_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          dropped_reg;
  logic          pop;
  logic          push;

  logic          tx_reg;
  logic          busy_reg;
  logic [3:0]    bit_idx_reg;
  logic [BW-1:0] baud_reg;
  logic [7:0]    data_reg;
  logic          dbg_b_reg;
  logic          eng_done;
  logic          eng_load;
  logic [7:0]    eng_byte;
  logic [31:0]   sel_word;
  logic          word_done;

  // ---------------- word FIFO ----------------
  assign pop  = (state_reg == W_IDLE) && !empty_reg;
  // A pop in the same cycle frees a slot, so a write to a full FIFO is still taken.
  assign push = i_write_next_word_cmd && (!full_reg || pop);

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Read-before-write: with a full FIFO both pointers match and the pop must see the old word.
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_fifo_input_word;
    end
    if (pop) begin
      fifo_q_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      full_reg    <= 1'b0;
      empty_reg   <= 1'b1;
      dropped_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg   <= count_next;
      full_reg    <= (count_next == DEPTH_C);
      empty_reg   <= (count_next == '0);
      dropped_reg <= i_write_next_word_cmd && !push;
    end
  end

  // ---------------- word serialiser ----------------
  assign word_done = (state_reg == W_SEND) && eng_done && (byte_idx_reg == 2'd3) && !hdr_active_reg;

  // The next byte is handed over in the last stop-bit cycle so frames run back to back.
  always_comb begin
    eng_load = 1'b0;
    eng_byte = 8'h00;
    sel_word = shift_reg << {byte_idx_reg + 2'd1, 3'b000};
    case (state_reg)
      W_LOAD: begin
        eng_load = 1'b1;
        eng_byte = hdr_req_reg ? HEADER_MSB : fifo_q_reg[31:24];
      end
      W_SEND: begin
        if (eng_done) begin
          if (byte_idx_reg != 2'd3) begin
            eng_load = 1'b1;
            eng_byte = sel_word[31:24];
          end else if (hdr_active_reg) begin
            eng_load = 1'b1;
            eng_byte = fifo_q_reg[31:24];
          end
        end
      end
      default: begin
        eng_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg      <= W_IDLE;
      byte_idx_reg   <= 2'd0;
      shift_reg      <= '0;
      hdr_req_reg    <= 1'b0;
      hdr_active_reg <= 1'b0;
      drained_reg    <= 1'b1;
    end else begin
      case (state_reg)
        W_IDLE: begin
          if (!empty_reg) begin
            state_reg   <= W_LOAD;
            hdr_req_reg <= HDR_EN && drained_reg;
            drained_reg <= 1'b0;
          end else begin
            drained_reg <= 1'b1;
          end
        end
        W_LOAD: begin
          shift_reg      <= hdr_req_reg ? HEADER_WORD : fifo_q_reg;
          hdr_active_reg <= hdr_req_reg;
          byte_idx_reg   <= 2'd0;
          state_reg      <= W_SEND;
        end
        W_SEND: begin
          if (eng_done) begin
            if (byte_idx_reg != 2'd3) begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end else if (hdr_active_reg) begin
              // Header finished; the popped word is still held in fifo_q_reg.
              shift_reg      <= fifo_q_reg;
              hdr_active_reg <= 1'b0;
              byte_idx_reg   <= 2'd0;
            end else begin
              state_reg <= W_IDLE;
            end
          end
        end
        default: begin
          state_reg <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------- UART bit engine ----------------
  assign eng_done = busy_reg && (bit_idx_reg == 4'd9) && (baud_reg == BAUD_LAST);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      bit_idx_reg <= 4'd0;
      baud_reg    <= '0;
      data_reg    <= 8'h00;
      dbg_b_reg   <= 1'b0;
    end else begin
      dbg_b_reg <= eng_load;
      if (eng_load) begin
        busy_reg    <= 1'b1;
        bit_idx_reg <= 4'd0;
        baud_reg    <= '0;
        data_reg    <= eng_byte;
        tx_reg      <= 1'b0;
      end else if (busy_reg) begin
        if (baud_reg == BAUD_LAST) begin
          baud_reg <= '0;
          if (bit_idx_reg == 4'd9) begin
            busy_reg <= 1'b0;
            tx_reg   <= 1'b1;
          end else begin
            bit_idx_reg <= bit_idx_reg + 4'd1;
            tx_reg      <= (bit_idx_reg == 4'd8) ? 1'b1 : data_reg[bit_idx_reg[2:0]];
          end
        end else begin
          baud_reg <= baud_reg + BW'(1);
        end
      end
    end
  end

  assign o_fifo_is_full_sig  = full_reg;
  assign o_fifo_is_empty_sig = empty_reg;
  assign o_write_dropped_sig = dropped_reg;
  assign o_tx_serial         = tx_reg;
  assign o_tx_active_sig     = (state_reg != W_IDLE) || busy_reg;
  assign o_word_sent_sig     = word_done;
  assign o_debug_out_b       = dbg_b_reg;
  assign o_debug_out_y       = pop;

endmodule

// File: tb/tb_pc_tx.sv
// Self-checking bench for pc_tx: a UART line decoder recovers frames, compared against a byte/gap model.
`timescale 1ns/1ps
module tb_pc_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef PC_TX_MAGIC_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [31:0] wdata;
  logic        full, empty, dropped, txs, active, word_sent, dbg_b, dbg_y;

  pc_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst), .i_write_next_word_cmd(wr), .i_fifo_input_word(wdata),
    .o_fifo_is_full_sig(full), .o_fifo_is_empty_sig(empty), .o_write_dropped_sig(dropped),
    .o_tx_serial(txs), .o_tx_active_sig(active), .o_word_sent_sig(word_sent),
    .o_debug_out_b(dbg_b), .o_debug_out_y(dbg_y)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // line monitor state
  int          cyc = 0;
  bit          mon_busy = 1'b0;
  int          mon_t0 = 0;
  logic [9:0]  mon_bits;
  logic [7:0]  rx_q[$];
  int          st_q[$];
  int          frame_err = 0, ws_cnt = 0, drop_cnt = 0, act_err = 0, dbgb_err = 0;
  bit          ws_prev = 1'b0;

  // reference model: expected bytes and start-to-start spacing (-1 = not checked)
  logic [7:0]  exp_b[$];
  int          exp_g[$];

  logic [31:0] burst[8];
  bit          drop_seen[8];
  bit          full_seen[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int k;
    if (rst) begin
      mon_busy = 1'b0;
      ws_prev  = 1'b0;
    end else begin
      if (word_sent) begin
        ws_cnt++;
        if (!active) act_err++;
      end
      if (ws_prev && active) act_err++;
      ws_prev = word_sent;
      if (dropped) drop_cnt++;
      if (!mon_busy) begin
        if (txs == 1'b0) begin
          mon_busy = 1'b1;
          mon_t0   = cyc;
          st_q.push_back(cyc);
          if (!dbg_b) dbgb_err++;
        end
      end else begin
        k = cyc - mon_t0;
        if (k % CPB == CPB / 2) begin
          mon_bits[k / CPB] = txs;
          if (k / CPB == 9) begin
            if (mon_bits[0] != 1'b0 || mon_bits[9] != 1'b1) frame_err++;
            rx_q.push_back(mon_bits[8:1]);
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Words go out MSB byte first; a new packet may carry the header; words 2 idle cycles apart.
  task automatic model_word(input logic [31:0] w, input bit new_packet);
    logic [31:0] hw;
    int g;
    hw = 32'hD78C_1B74;
    g  = new_packet ? -1 : 10 * CPB + 2;
    if (HDR && new_packet) begin
      for (int k = 0; k < 4; k++) begin
        exp_b.push_back(hw[31 - 8 * k -: 8]);
        exp_g.push_back(k == 0 ? -1 : 10 * CPB);
      end
      g = 10 * CPB;
    end
    for (int k = 0; k < 4; k++) begin
      exp_b.push_back(w[31 - 8 * k -: 8]);
      exp_g.push_back(k == 0 ? g : 10 * CPB);
    end
  endtask

  task automatic push_burst(input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      wr = 1'b1;
      wdata = burst[i];
      @(posedge clk); #1;
      drop_seen[i] = dropped;
      full_seen[i] = full;
    end
    wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t, run;
    t = 0;
    run = 0;
    while (run < 8 && t < 20000) begin
      @(negedge clk);
      t++;
      if (active === 1'b0 && empty === 1'b1 && !mon_busy) run++;
      else run = 0;
    end
    chk({tag, " idle_timeout"}, 32'(t < 20000), 32'd1);
  endtask

  task automatic wait_busy_empty(input string tag);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(active === 1'b1 && empty === 1'b1) && t < 200);
    chk({tag, " pop_timeout"}, 32'(t < 200), 32'd1);
  endtask

  task automatic check_frames(input string tag);
    wait_idle(tag);
    chk({tag, " frames"}, rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      chk($sformatf("%s byte%0d", tag, i), rx_q[i], exp_b[i]);
      if (exp_g[i] >= 0 && i < st_q.size())
        chk($sformatf("%s gap%0d", tag, i), st_q[i] - st_q[i - 1], exp_g[i]);
    end
    chk({tag, " framing"}, frame_err, 0);
    rx_q.delete();
    st_q.delete();
    exp_b.delete();
    exp_g.delete();
  endtask

  initial begin
    logic [31:0] w;
    int ws0, d0, target, t;

    rst = 1'b1;
    wr = 1'b0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx", txs, 1);
    chk("rst active", active, 0);
    chk("rst full", full, 0);
    chk("rst empty", empty, 1);
    chk("rst dropped", dropped, 0);
    chk("rst word_sent", word_sent, 0);
    chk("rst dbg_b", dbg_b, 0);
    chk("rst dbg_y", dbg_y, 0);
    rst = 1'b0;

    // single words
    ws0 = ws_cnt;
    model_word(32'h416F_DC1E, 1'b1);
    burst[0] = 32'h416F_DC1E;
    push_burst(1);
    check_frames("single");
    chk("single word_sent", ws_cnt - ws0, 1);
    for (int r = 0; r < 3; r++) begin
      w = $urandom;
      model_word(w, 1'b1);
      burst[0] = w;
      push_burst(1);
      check_frames("rand_single");
    end

    // two words on consecutive cycles
    for (int r = 0; r < 3; r++) begin
      burst[0] = (r == 0) ? 32'h0102_0304 : $urandom;
      burst[1] = (r == 0) ? 32'hA5A5_A5A5 : $urandom;
      model_word(burst[0], 1'b1);
      model_word(burst[1], 1'b0);
      ws0 = ws_cnt;
      push_burst(2);
      check_frames("pair");
      chk("pair word_sent", ws_cnt - ws0, 2);
    end

    // overflow: 5 pushes while word 1 is in flight, the one into a full FIFO is dropped
    d0 = drop_cnt;
    w = $urandom;
    model_word(w, 1'b1);
    burst[0] = w;
    push_burst(1);
    wait_busy_empty("drop");
    for (int i = 0; i < 5; i++) begin
      burst[i] = $urandom;
      if (i < DEPTH) model_word(burst[i], 1'b0);
    end
    push_burst(5);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("drop accept%0d", i), drop_seen[i], 0);
    chk("drop full", full_seen[DEPTH - 1], 1);
    chk("drop pulse", drop_seen[DEPTH], 1);
    chk("drop full_kept", full_seen[DEPTH], 1);
    check_frames("drop");
    chk("drop count", drop_cnt - d0, 1);

    // reset in the middle of byte 2
    burst[0] = $urandom;
    burst[1] = $urandom;
    push_burst(2);
    target = HDR ? 6 : 2;
    t = 0;
    while (st_q.size() <= target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid start_timeout", 32'(t < 3000), 32'd1);
    if (st_q.size() > target) begin
      while (cyc < st_q[target] + 5 * CPB + 1) @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid tx", txs, 1);
    chk("rst_mid empty", empty, 1);
    chk("rst_mid active", active, 0);
    chk("rst_mid full", full, 0);
    rst = 1'b0;
    rx_q.delete();
    st_q.delete();
    w = $urandom;
    model_word(w, 1'b1);
    burst[0] = w;
    push_burst(1);
    check_frames("after_reset");

    // full FIFO, push in the same cycle as a pop
    d0 = drop_cnt;
    w = $urandom;
    model_word(w, 1'b1);
    burst[0] = w;
    push_burst(1);
    wait_busy_empty("fullpop");
    for (int i = 0; i < DEPTH; i++) begin
      burst[i] = $urandom;
      model_word(burst[i], 1'b0);
    end
    push_burst(DEPTH);
    chk("fullpop full", full_seen[DEPTH - 1], 1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (word_sent !== 1'b1 && t < 1000);
    chk("fullpop ws_timeout", 32'(t < 1000), 32'd1);
    @(posedge clk); #1;
    w = $urandom;
    wr = 1'b1;
    wdata = w;
    @(negedge clk);
    chk("fullpop pop_strobe", dbg_y, 1);
    @(posedge clk); #1;
    wr = 1'b0;
    chk("fullpop full_after", full, 1);
    chk("fullpop dropped", dropped, 0);
    model_word(w, 1'b0);
    check_frames("fullpop");
    chk("fullpop drop_count", drop_cnt - d0, 0);

    chk("active_vs_word_sent", act_err, 0);
    chk("dbg_b_on_start", dbgb_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
